e_mdu: RTL

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It takes the decoded MDU operation and the forwarded rs/rt operands of the instruction held in the D/E pipeline register. It runs multi-cycle multiply and divide into private HI/LO registers and serves mfhi/mflo reads to the E-stage result mux. It also drives a stall request so the hazard logic can freeze the PC, F/D and D/E registers while a D-stage MDU instruction waits for a busy unit.

---
 rtl/e_mdu.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// -----------------------------------------------------------------------------
// e_mdu : execute-stage multiply/divide unit for the five-stage MIPS pipeline.
//
// Runs multi-cycle mult/multu/div/divu (and optionally madd/maddu) into private
// HI/LO registers. It serves mfhi/mflo reads to the E-stage result mux and
// requests a pipeline stall while a D-stage MDU instruction must wait for the
// unit.
//
// Optional feature macro: MDU_MADD_EN
//   defined   -> ops 9/10 (madd/maddu) accumulate the product into {HI,LO}
//   undefined -> ops 9/10 are treated as "none" and no accumulator is built
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu/madd/maddu (>=1)
//   DIV_CYCLES   busy cycles for div/divu (>=1)
//
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   synchronous, active-high reset
//   E_MDU_op      in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,
//                          7 mthi,8 mtlo,9 madd,10 maddu (11-15 = none)
//   E_rs_data     in  32   forwarded rs operand
//   E_rt_data     in  32   forwarded rt operand
//   D_MDU_use     in   1   D-stage instruction is an MDU op
//   E_MDU_result  out 32   HI for mfhi, LO for mflo, else 0
//   MDU_busy      out  1   operation in progress
//   MDU_stall     out  1   stall request to the hazard unit
//   HI            out 32   current HI register
//   LO            out 32   current LO register
// -----------------------------------------------------------------------------
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDU_op,
   input  logic [31:0] E_rs_data,
   input  logic [31:0] E_rt_data,
   input  logic        D_MDU_use,
   output logic [31:0] E_MDU_result,
   output logic        MDU_busy,
   output logic        MDU_stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
`endif

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic [31:0]        r_pend_hi;
   logic [31:0]        r_pend_lo;
   logic               r_pend_wr;

   logic               w_busy;
   logic               w_start_op;
   logic               w_start;
   logic               w_is_div;
   logic               w_last;
   logic [63:0]        w_res;
   logic               w_res_wr;

   logic signed [63:0] w_rs_sx;
   logic signed [63:0] w_rt_sx;
   logic signed [63:0] w_prod_s;
   logic [63:0]        w_prod_u;

   // Signed divide on magnitudes: the quotient truncates toward zero and the
   // remainder takes the dividend's sign. Going through magnitudes keeps
   // 0x80000000 / -1 well defined (quotient wraps back to 0x80000000).
   // Returns {remainder, quotient}.
   function automatic logic [63:0] f_div_s(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ma, mb, q, r;
      ma = a[31] ? (~a + 32'd1) : a;
      mb = b[31] ? (~b + 32'd1) : b;
      q  = ma / mb;
      r  = ma % mb;
      if (a[31] ^ b[31]) q = ~q + 32'd1;
      if (a[31])         r = ~r + 32'd1;
      return {r, q};
   endfunction

   // Unsigned divide, returns {remainder, quotient}.
   function automatic logic [63:0] f_div_u(input logic [31:0] a, input logic [31:0] b);
      return {a % b, a / b};
   endfunction

   assign w_busy = (r_state == S_BUSY);
   assign w_last = (r_cnt == CNT_W'(1));

   always_comb begin
      w_start_op = 1'b0;
      case (E_MDU_op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_start_op = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU:                  w_start_op = 1'b1;
`endif
         default:                            w_start_op = 1'b0;
      endcase
   end

   assign w_start  = w_start_op & ~w_busy;
   assign w_is_div = (E_MDU_op == OP_DIV) || (E_MDU_op == OP_DIVU);

   assign w_rs_sx  = {{32{E_rs_data[31]}}, E_rs_data};
   assign w_rt_sx  = {{32{E_rt_data[31]}}, E_rt_data};
   assign w_prod_s = w_rs_sx * w_rt_sx;
   assign w_prod_u = {32'd0, E_rs_data} * {32'd0, E_rt_data};

   // Result computed at start and held in the pending registers until the
   // last busy cycle. A zero divisor suppresses the final HI/LO write.
   always_comb begin
      w_res    = 64'd0;
      w_res_wr = 1'b1;
      case (E_MDU_op)
         OP_MULT:  w_res = w_prod_s;
         OP_MULTU: w_res = w_prod_u;
         OP_DIV: begin
            if (E_rt_data != 32'd0) w_res = f_div_s(E_rs_data, E_rt_data);
            else                    w_res_wr = 1'b0;
         end
         OP_DIVU: begin
            if (E_rt_data != 32'd0) w_res = f_div_u(E_rs_data, E_rt_data);
            else                    w_res_wr = 1'b0;
         end
`ifdef MDU_MADD_EN
         // Accumulates onto HI/LO as they stand at start; wraps mod 2^64.
         OP_MADD:  w_res = {r_hi, r_lo} + w_prod_s;
         OP_MADDU: w_res = {r_hi, r_lo} + w_prod_u;
`endif
         default:  w_res = 64'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
         S_BUSY:  if (w_last)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_wr <= 1'b0;
      end else if (w_start) begin
         r_pend_hi <= w_res[63:32];
         r_pend_lo <= w_res[31:0];
         r_pend_wr <= w_res_wr;
         r_cnt     <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (w_busy) begin
         r_cnt <= r_cnt - CNT_W'(1);
         if (w_last && r_pend_wr) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
      end else begin
         // Moves to HI/LO only land while idle; during busy they are dropped.
         if (E_MDU_op == OP_MTHI) r_hi <= E_rs_data;
         if (E_MDU_op == OP_MTLO) r_lo <= E_rs_data;
      end
   end

   always_comb begin
      E_MDU_result = 32'd0;
      if (E_MDU_op == OP_MFHI) E_MDU_result = r_hi;
      if (E_MDU_op == OP_MFLO) E_MDU_result = r_lo;
   end

   assign MDU_busy  = w_busy;
   assign MDU_stall = D_MDU_use & (w_start | w_busy);
   assign HI        = r_hi;
   assign LO        = r_lo;

endmodule
